wavetable_reader: RTL and testbench

- Oscillator front-end that sits directly upstream of the 256x32 single-port on-chip wavetable RAM.
- Acts as a read-only Avalon-MM master on that RAM's slave port.
- Runs a phase accumulator and fetches the two adjacent table entries for each output sample.
- Linearly interpolates between them and delivers one signed sample per valid/ready handshake to the downstream mixer/DAC path.

---
 rtl/wavetable_reader_if.sv | 32 +++
 rtl/wavetable_reader.sv | 138 +++++++++++++
 tb/tb_wavetable_reader.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/wavetable_reader_if.sv
// Bus bundle for the wavetable reader: Avalon-MM read master towards the
// wavetable RAM plus the valid/ready sample stream towards the mixer/DAC.
interface wavetable_reader_if #(
   parameter int ADDR_W   = 8,
   parameter int SAMPLE_W = 16
);
   logic [ADDR_W-1:0]   mem_address;
   logic                mem_chipselect;
   logic                mem_write;
   logic [3:0]          mem_byteenable;
   logic                mem_clken;
   logic [31:0]         mem_readdata;
   logic [SAMPLE_W-1:0] out_sample;
   logic                out_valid;
   logic                out_ready;

   // Reader side: drives the RAM address/controls and the sample stream.
   modport master (
      output mem_address, mem_chipselect, mem_write, mem_byteenable, mem_clken,
      input  mem_readdata,
      output out_sample, out_valid,
      input  out_ready
   );

   // RAM / downstream side.
   modport slave (
      input  mem_address, mem_chipselect, mem_write, mem_byteenable, mem_clken,
      output mem_readdata,
      input  out_sample, out_valid,
      output out_ready
   );
endinterface

// File: rtl/wavetable_reader.sv
// Wavetable oscillator front-end: phase accumulator, two-word fetch from the
// single-port wavetable RAM (one-cycle read latency) and linear interpolation,
// delivering one signed sample per valid/ready handshake.
module wavetable_reader #(
   parameter int ADDR_W   = 8,
   parameter int PHASE_W  = 32,
   parameter int FRAC_W   = 8,
   parameter int SAMPLE_W = 16
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               enable,
   input  logic               phase_reset,
   input  logic [PHASE_W-1:0] tuning_word,
   wavetable_reader_if.master bus
);

   localparam int DIFF_W = SAMPLE_W + 1;
   localparam int PROD_W = SAMPLE_W + FRAC_W + 2;

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      RD0  = 3'd1,
      RD1  = 3'd2,
      WAIT = 3'd3,
      CALC = 3'd4,
      OUT  = 3'd5
   } state_t;

   state_t                      state_reg, state_next;
   logic [PHASE_W-1:0]          phase_reg;
   logic [PHASE_W-1:0]          tw_reg;
   logic [ADDR_W-1:0]           idx_reg;
   logic [FRAC_W-1:0]           frac_reg;
   logic signed [SAMPLE_W-1:0]  s0_reg, s1_reg;
   logic [SAMPLE_W-1:0]         out_sample_reg;
   logic                        out_valid_reg;

   logic [ADDR_W-1:0]           mem_address_next;
   logic                        mem_chipselect_next;

   logic signed [DIFF_W-1:0]    diff;
   logic signed [PROD_W-1:0]    prod;
   logic signed [PROD_W-1:0]    interp;

   // The RAM port is read-only and always clocked.
   assign bus.mem_write      = 1'b0;
   assign bus.mem_byteenable = 4'hF;
   assign bus.mem_clken      = 1'b1;
   // Address/chipselect decode straight from the state register, so the
   // async reset drops chipselect immediately.
   assign bus.mem_address    = mem_address_next;
   assign bus.mem_chipselect = mem_chipselect_next;
   assign bus.out_sample     = out_sample_reg;
   assign bus.out_valid      = out_valid_reg;

   // State register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state_reg <= IDLE;
      else       state_reg <= state_next;
   end

   // Next-state logic and RAM address/chipselect decode.
   always_comb begin
      state_next          = state_reg;
      mem_chipselect_next = 1'b0;
      mem_address_next    = idx_reg;
      case (state_reg)
         IDLE: if (enable) state_next = RD0;
         RD0: begin
            // idx is latched at the end of this cycle; present it from the phase now
            mem_chipselect_next = 1'b1;
            mem_address_next    = phase_reg[PHASE_W-1 -: ADDR_W];
            state_next          = RD1;
         end
         RD1: begin
            // natural wrap of the ADDR_W-bit add gives 255 -> 0
            mem_chipselect_next = 1'b1;
            mem_address_next    = idx_reg + ADDR_W'(1);
            state_next          = WAIT;
         end
         WAIT: state_next = CALC;
         CALC: state_next = OUT;
         OUT:  if (bus.out_ready) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Per-sample operand latches: phase fields in RD0, table words as they return.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         idx_reg  <= '0;
         frac_reg <= '0;
         tw_reg   <= '0;
         s0_reg   <= '0;
         s1_reg   <= '0;
      end else begin
         case (state_reg)
            RD0: begin
               idx_reg  <= phase_reg[PHASE_W-1 -: ADDR_W];
               frac_reg <= phase_reg[PHASE_W-ADDR_W-1 -: FRAC_W];
               tw_reg   <= tuning_word;
            end
            RD1:  s0_reg <= bus.mem_readdata[SAMPLE_W-1:0];
            WAIT: s1_reg <= bus.mem_readdata[SAMPLE_W-1:0];
            default: ;
         endcase
      end
   end

   // Phase accumulator: advances once per sample in CALC; phase_reset wins.
   always_ff @(posedge clk or posedge reset) begin
      if (reset)                  phase_reg <= '0;
      else if (phase_reset)       phase_reg <= '0;
      else if (state_reg == CALC) phase_reg <= phase_reg + tw_reg;
   end

   // Linear interpolation s0 + floor((s1 - s0) * frac / 2^FRAC_W).
   always_comb begin
      diff   = DIFF_W'(s1_reg) - DIFF_W'(s0_reg);
      prod   = PROD_W'(diff) * PROD_W'($signed({1'b0, frac_reg}));
      interp = PROD_W'(s0_reg) + (prod >>> FRAC_W);
   end

   // Output register: loaded in CALC, held through backpressure, cleared on accept.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         out_sample_reg <= '0;
         out_valid_reg  <= 1'b0;
      end else if (state_reg == CALC) begin
         out_sample_reg <= interp[SAMPLE_W-1:0];
         out_valid_reg  <= 1'b1;
      end else if (state_reg == OUT && bus.out_ready) begin
         out_valid_reg  <= 1'b0;
      end
   end

endmodule

// File: tb/tb_wavetable_reader.sv
// Bench for wavetable_reader: a RAM model with one-cycle read latency,
// directed samples with hand-computed results pushed into a scoreboard, and a
// monitor that pops and compares on every output handshake.
module tb_wavetable_reader;

   logic        clk = 1'b0;
   logic        reset;
   logic        enable;
   logic        phase_reset;
   logic [31:0] tuning_word;

   logic [31:0] mem [256];
   logic [31:0] rdata;
   logic [15:0] sb_q [$];
   logic [31:0] ph_model;
   int          n_checks = 0;
   int          n_fail   = 0;

   wavetable_reader_if bus ();

   wavetable_reader dut (
      .clk         (clk),
      .reset       (reset),
      .enable      (enable),
      .phase_reset (phase_reset),
      .tuning_word (tuning_word),
      .bus         (bus)
   );

   always #5 clk = ~clk;

   // RAM model: registered read, data valid the cycle after the address
   always @(posedge clk) rdata <= mem[bus.mem_address];
   assign bus.mem_readdata = rdata;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, required %h", name, act, exp);
      end
   endtask

   // Monitor: compare every accepted sample against the scoreboard head
   always begin
      @(negedge clk);
      #1;
      if (!reset && bus.out_valid && bus.out_ready) begin
         if (sb_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_sample: got %h, required no sample", bus.out_sample);
         end else begin
            logic [15:0] e;
            e = sb_q.pop_front();
            chk("sample", {16'h0, bus.out_sample}, {16'h0, e});
            $display("sample %h accepted (expected %h)", bus.out_sample, e);
         end
      end
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic reset_dut();
      reset = 1'b1;
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;
      ph_model = 32'h0;
   endtask

   // One full fetch starting at a negedge with the DUT idle. Cycle k is the
   // k-th cycle after the edge on which IDLE samples enable.
   task automatic do_sample(input logic [31:0] tw, input logic [15:0] exp,
                            input int hold, input int pr_cyc);
      logic [7:0]  idx0, idx1;
      logic [15:0] held;
      sb_q.push_back(exp);
      idx0 = ph_model[31:24];
      idx1 = idx0 + 8'd1;
      enable      = 1'b1;
      tuning_word = tw;
      bus.out_ready = (hold == 0);
      @(posedge clk);
      for (int cyc = 1; cyc <= 5; cyc++) begin
         @(negedge clk);
         enable      = 1'b0;
         phase_reset = (cyc == pr_cyc);
         case (cyc)
            1: begin
               chk("cs_rd0", {31'h0, bus.mem_chipselect}, 32'h1);
               chk("addr_rd0", {24'h0, bus.mem_address}, {24'h0, idx0});
            end
            2: begin
               chk("cs_rd1", {31'h0, bus.mem_chipselect}, 32'h1);
               chk("addr_rd1", {24'h0, bus.mem_address}, {24'h0, idx1});
            end
            3: chk("cs_wait", {31'h0, bus.mem_chipselect}, 32'h0);
            4: chk("valid_calc", {31'h0, bus.out_valid}, 32'h0);
            default: chk("valid_out", {31'h0, bus.out_valid}, 32'h1);
         endcase
      end
      ph_model = (pr_cyc == 4) ? 32'h0 : ph_model + tw;
      held = bus.out_sample;
      for (int h = 1; h <= hold; h++) begin
         @(negedge clk);
         chk("hold_sample", {16'h0, bus.out_sample}, {16'h0, held});
         chk("hold_cs", {31'h0, bus.mem_chipselect | ~bus.out_valid}, 32'h0);
         chk("hold_phase", dut.phase_reg, ph_model);
      end
      bus.out_ready = 1'b1;
      @(posedge clk);
      #1;
      chk("valid_clear", {31'h0, bus.out_valid}, 32'h0);
      chk("phase", dut.phase_reg, ph_model);
      @(negedge clk);
   endtask

   initial begin
      logic bad;
      reset         = 1'b1;
      enable        = 1'b0;
      phase_reset   = 1'b0;
      tuning_word   = 32'h0;
      bus.out_ready = 1'b1;
      ph_model      = 32'h0;
      for (int i = 0; i < 256; i++) mem[i] = 32'h0;
      repeat (3) @(negedge clk);
      reset = 1'b0;

      // reset state
      chk("rst_valid", {31'h0, bus.out_valid}, 32'h0);
      chk("rst_sample", {16'h0, bus.out_sample}, 32'h0);
      chk("rst_cs", {31'h0, bus.mem_chipselect}, 32'h0);
      chk("rst_addr", {24'h0, bus.mem_address}, 32'h0);
      chk("rst_phase", dut.phase_reg, 32'h0);
      chk("const_ctl", {28'h0, bus.mem_byteenable}, 32'hF);
      chk("const_wr_clken", {30'h0, bus.mem_write, bus.mem_clken}, 32'h1);

      // basic fetch: 100 at frac 0, then 150 at frac 0x80
      mem[0] = 32'hDEAD_0064;
      mem[1] = 32'h0000_00C8;
      do_sample(32'h0080_0000, 16'd100, 0, 0);
      do_sample(32'h0000_0000, 16'd150, 0, 0);

      // -1000 -> 1000 at frac 0x40 gives -500
      mem[0] = 32'hFFFF_FC18;
      mem[1] = 32'h0000_03E8;
      reset_dut();
      do_sample(32'h0040_0000, 16'hFC18, 0, 0);
      do_sample(32'h0000_0000, 16'hFE0C, 0, 0);

      // 1000 -> -1000 at frac 0x40 gives 500
      mem[0] = 32'h0000_03E8;
      mem[1] = 32'h5555_FC18;
      reset_dut();
      do_sample(32'h0040_0000, 16'h03E8, 0, 0);
      do_sample(32'h0000_0000, 16'h01F4, 0, 0);

      // 0 -> -1 at frac 0x01 floors to -1; upper data bits ignored
      mem[0] = 32'h1234_0000;
      mem[1] = 32'hABCD_FFFF;
      reset_dut();
      do_sample(32'h0001_0000, 16'h0000, 0, 0);
      do_sample(32'h0000_0000, 16'hFFFF, 0, 0);

      // table wrap 255 -> 0 with 10 cycles of backpressure, then phase wrap
      mem[255] = 32'h0000_7FFF;
      mem[0]   = 32'h0000_0000;
      mem[1]   = 32'h0000_0040;
      reset_dut();
      do_sample(32'hFF80_0000, 16'h0000, 0, 0);
      do_sample(32'h0100_0000, 16'h3FFF, 10, 0);
      chk("phase_wrap", dut.phase_reg, 32'h0080_0000);
      do_sample(32'h0000_0000, 16'h0020, 0, 0);

      // reset during RD1 aborts the fetch with no partial sample
      enable = 1'b1;
      @(posedge clk);
      @(negedge clk);
      enable = 1'b0;
      @(negedge clk);
      chk("rd1_cs", {31'h0, bus.mem_chipselect}, 32'h1);
      reset = 1'b1;
      #1;
      chk("abort_cs", {31'h0, bus.mem_chipselect}, 32'h0);
      chk("abort_valid", {31'h0, bus.out_valid}, 32'h0);
      chk("abort_state", {29'h0, dut.state_reg}, 32'h0);
      @(negedge clk);
      reset = 1'b0;
      ph_model = 32'h0;
      bad = 1'b0;
      repeat (8) begin
         @(negedge clk);
         if (bus.out_valid) bad = 1'b1;
      end
      chk("no_partial", {31'h0, bad}, 32'h0);

      // phase_reset in CALC: in-flight sample delivered, phase cleared
      mem[0] = 32'h0000_0111;
      mem[1] = 32'h0000_0222;
      reset_dut();
      do_sample(32'h0300_0000, 16'h0111, 0, 4);
      chk("phase_after_pr", dut.phase_reg, 32'h0);
      do_sample(32'h0300_0000, 16'h0111, 0, 0);
      chk("phase_after_next", dut.phase_reg, 32'h0300_0000);

      repeat (3) @(negedge clk);
      chk("scoreboard_empty", sb_q.size(), 32'h0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
